// File: rtl/reg_display_pager_if.sv
// Bus bundle for reg_display_pager: register source values, operator
// controls and the 7-segment / page outputs.
interface reg_display_pager_if #(
  parameter int NREG  = 8,
  parameter int WIDTH = 16
);
  logic [NREG*WIDTH-1:0] regs_i;
  logic                  step_i;
  logic                  auto_en_i;
  logic                  capture_i;
  logic [55:0]           hex_n_o;
  logic [3:0]            page_o;

  modport master (
    output regs_i, step_i, auto_en_i, capture_i,
    input  hex_n_o, page_o
  );

  modport slave (
    input  regs_i, step_i, auto_en_i, capture_i,
    output hex_n_o, page_o
  );
endinterface

// File: rtl/reg_display_pager.sv
// reg_display_pager: pages NREG registers across eight active-low hex
// digits. Pages advance on a synchronized step press or an auto-scroll tick.
// Optional macro REG_DISPLAY_SNAPSHOT_EN: display a snapshot loaded by
// capture instead of the live register values.
module reg_display_pager #(
  parameter int NREG     = 8,
  parameter int WIDTH    = 16,
  parameter int DPR      = 2,
  parameter int AUTO_DIV = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_display_pager_if.slave bus
);
  localparam int P               = 8 / DPR;
  localparam int NPAGE           = (NREG + P - 1) / P;
  localparam logic [3:0] LAST_PG = 4'(NPAGE - 1);
  localparam int CW              = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(AUTO_DIV - 1);

  logic [1:0]            step_sync_q;
  logic [1:0]            auto_sync_q;
  logic [1:0]            fill_q;
  logic                  step_prev_q;
  logic                  step_adv_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            page_q;
  logic [55:0]           hex_q;
  logic [55:0]           hex_d;
  logic [NREG*WIDTH-1:0] src;
  logic                  tick;
  logic                  unused_ok;

  // Active-low glyph for one nibble; bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] glyph_n(input logic [3:0] v);
    case (v)
      4'h0: glyph_n = 7'h40;
      4'h1: glyph_n = 7'h79;
      4'h2: glyph_n = 7'h24;
      4'h3: glyph_n = 7'h30;
      4'h4: glyph_n = 7'h19;
      4'h5: glyph_n = 7'h12;
      4'h6: glyph_n = 7'h02;
      4'h7: glyph_n = 7'h78;
      4'h8: glyph_n = 7'h00;
      4'h9: glyph_n = 7'h10;
      4'hA: glyph_n = 7'h08;
      4'hB: glyph_n = 7'h03;
      4'hC: glyph_n = 7'h46;
      4'hD: glyph_n = 7'h21;
      4'hE: glyph_n = 7'h06;
      default: glyph_n = 7'h0E;
    endcase
  endfunction

  // Two-flop synchronizers plus registered step edge detect. The edge
  // memory is held high until the synchronizer has refilled after reset,
  // so a button held through reset release never counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync_q <= '0;
      auto_sync_q <= '0;
      fill_q      <= '0;
      step_prev_q <= 1'b1;
      step_adv_q  <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[0], bus.step_i};
      auto_sync_q <= {auto_sync_q[0], bus.auto_en_i};
      fill_q      <= {fill_q[0], 1'b1};
      step_prev_q <= fill_q[1] ? step_sync_q[1] : 1'b1;
      step_adv_q  <= step_sync_q[1] & ~step_prev_q;
    end
  end

  assign tick = auto_sync_q[1] && (cnt_q == CNT_LAST);

  // Auto-scroll prescaler and page counter; a step advance restarts the
  // prescaler and a coincident tick merges into the same single advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      page_q <= '0;
    end else begin
      if (!auto_sync_q[1] || step_adv_q || tick) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + CW'(1);
      if (step_adv_q || tick)
        page_q <= (page_q == LAST_PG) ? 4'd0 : page_q + 4'd1;
    end
  end

`ifdef REG_DISPLAY_SNAPSHOT_EN
  logic [NREG*WIDTH-1:0] snap_q;

  // Snapshot of all registers taken on a capture pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             snap_q <= '0;
    else if (bus.capture_i) snap_q <= bus.regs_i;
  end

  assign src       = snap_q;
  assign unused_ok = ^src;
`else
  assign src       = bus.regs_i;
  assign unused_ok = ^{src, bus.capture_i};
`endif

  // Per-digit source selection: slot 0 fills the leftmost digits and the
  // leftmost digit of a slot carries its most significant displayed nibble.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    localparam int SLOT = (7 - gi) / DPR;
    localparam int NIB  = DPR - 1 - ((7 - gi) % DPR);
    logic [3:0] nib;
    logic       valid;
    logic [6:0] seg;

    // Pick the nibble for this digit, or blank past the last register.
    always_comb begin
      nib   = 4'd0;
      valid = 1'b0;
      for (int r = 0; r < NREG; r++) begin
        if (int'(page_q) * P + SLOT == r) begin
          nib   = src[r*WIDTH + NIB*4 +: 4];
          valid = 1'b1;
        end
      end
      seg = valid ? glyph_n(nib) : 7'h7F;
    end

    assign hex_d[7*gi +: 7] = seg;
  end

  // Registered digit outputs, blank while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex_q <= '1;
    else        hex_q <= hex_d;
  end

  assign bus.hex_n_o = hex_q;
  assign bus.page_o  = page_q;
endmodule

// File: tb/tb_reg_display_pager.sv
// Bench for reg_display_pager: two instances (6x16 bit, two digits per
// register; 3x16 bit, four digits per register) share the same stimulus
// and are compared every cycle with an event-level model.
module tb_reg_display_pager;
  localparam int AUTO_DIV = 4;
  localparam int NPAGE    = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step, auto_en, capture;
  logic [15:0] r [6];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_display_pager_if #(.NREG(6), .WIDTH(16)) bus1 ();
  reg_display_pager_if #(.NREG(3), .WIDTH(16)) bus2 ();

  assign bus1.regs_i    = {r[5], r[4], r[3], r[2], r[1], r[0]};
  assign bus2.regs_i    = {r[2], r[1], r[0]};
  assign bus1.step_i    = step;
  assign bus2.step_i    = step;
  assign bus1.auto_en_i = auto_en;
  assign bus2.auto_en_i = auto_en;
  assign bus1.capture_i = capture;
  assign bus2.capture_i = capture;

  reg_display_pager #(.NREG(6), .WIDTH(16), .DPR(2), .AUTO_DIV(AUTO_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  reg_display_pager #(.NREG(3), .WIDTH(16), .DPR(4), .AUTO_DIV(AUTO_DIV)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // ---------------- model ----------------
  int          m_n;
  int          m_page;
  logic [55:0] m_hex1, m_hex2;
  logic [15:0] m_snap [6];
  int          step_due [$];
  logic        prev_s, a_prev_sample, a_eff;
  int          next_auto;

  function automatic logic [55:0] build_hex(input logic [15:0] rv [6], input int nreg,
                                            input int dpr, input int pg);
    logic [55:0] h;
    logic [3:0]  nib;
    int          slot, pos, idx;
    h = '1;
    for (int k = 0; k < 8; k++) begin
      slot = (7 - k) / dpr;
      pos  = (7 - k) % dpr;
      idx  = pg * (8 / dpr) + slot;
      if (idx < nreg) begin
        nib = 4'(rv[idx] >> (4 * (dpr - 1 - pos)));
        h[7*k +: 7] = GLYPH[nib];
      end
    end
    return h;
  endfunction

  always @(posedge clk) begin
    logic [15:0] src [6];
    bit          adv;
    logic        a_eff_new;
    if (!rst_n) begin
      m_n = 0; m_page = 0; m_hex1 = '1; m_hex2 = '1;
      for (int i = 0; i < 6; i++) m_snap[i] = '0;
      step_due.delete();
      prev_s = 1'b1; a_prev_sample = 1'b0; a_eff = 1'b0; next_auto = -1;
    end else begin
      m_n++;
`ifdef REG_DISPLAY_SNAPSHOT_EN
      src = m_snap;
`else
      src = r;
`endif
      m_hex1 = build_hex(src, 6, 2, m_page);
      m_hex2 = build_hex(src, 3, 4, m_page);
      adv = 1'b0;
      if (step_due.size() > 0 && step_due[0] == m_n) begin
        void'(step_due.pop_front());
        adv = 1'b1;
      end
      if (a_eff && next_auto == m_n) adv = 1'b1;
      if (adv) m_page = (m_page + 1) % NPAGE;
      if (step && !prev_s) step_due.push_back(m_n + 3);
      prev_s        = step;
      a_eff_new     = a_prev_sample;
      a_prev_sample = auto_en;
      if (a_eff_new && (!a_eff || adv)) next_auto = m_n + AUTO_DIV;
      a_eff = a_eff_new;
      if (capture) m_snap = r;
    end
  end

  task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    chk("page1", 56'(bus1.page_o), 56'(m_page));
    chk("hex1",  bus1.hex_n_o, m_hex1);
    chk("page2", 56'(bus2.page_o), 56'(m_page));
    chk("hex2",  bus2.hex_n_o, m_hex2);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_capture();
    capture = 1'b1; cyc(1); capture = 1'b0;
  endtask

  task automatic press();
    step = 1'b1; cyc(5); step = 1'b0; cyc(6);
  endtask

  task automatic wait_for(input string name, input int cond_sel);
    int k;
    bit ok;
    k = 0; ok = 1'b0;
    while (!ok && k < 20) begin
      if (cond_sel == 0) ok = a_eff && (next_auto == m_n + 4);
      else               ok = (m_page == 1) && a_eff && (next_auto == m_n + 2);
      if (!ok) begin cyc(1); k++; end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: condition not reached within %0d cycles", name, k);
    end
  endtask

  initial begin
    int pg0;
    step = 1'b0; auto_en = 1'b0; capture = 1'b0;
    for (int i = 0; i < 6; i++) r[i] = 16'(16'h0011 * (i + 1));
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    pulse_capture();
    cyc(3);
    chk("r029_hex",  bus1.hex_n_o, {7'h79, 7'h79, 7'h24, 7'h24, 7'h30, 7'h30, 7'h19, 7'h19});
    chk("r029_page", 56'(bus1.page_o), 56'd0);
    chk("dpr4_p0",   bus2.hex_n_o, {7'h40, 7'h40, 7'h79, 7'h79, 7'h40, 7'h40, 7'h24, 7'h24});

    press();
    chk("r030_page", 56'(bus1.page_o), 56'd1);
    chk("r030_hex",  bus1.hex_n_o, {7'h12, 7'h12, 7'h02, 7'h02, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    press();
    chk("r030_wrap", 56'(bus1.page_o), 56'd0);

    r[2] = 16'hBEEF;
    pulse_capture();
    press();
    chk("r034_hex",  bus2.hex_n_o, {7'h03, 7'h06, 7'h06, 7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    chk("r034_page", 56'(bus2.page_o), 56'd1);
    press();

    // Auto-scroll, then a step advance landing on a tick edge.
    auto_en = 1'b1;
    cyc(14);
    wait_for("coinc_wait", 0);
    pg0 = m_page;
    step = 1'b1;
    cyc(3);
    chk("r031_before", 56'(bus1.page_o), 56'(pg0));
    cyc(1);
    chk("r031_once",   56'(bus1.page_o), 56'((pg0 + 1) % NPAGE));
    cyc(3);
    chk("r031_hold",   56'(bus1.page_o), 56'((pg0 + 1) % NPAGE));
    cyc(1);
    chk("r031_next",   56'(bus1.page_o), 56'(pg0));
    step = 1'b0;

    // Reset mid-scroll at page 1 with step held through release.
    wait_for("r033_wait", 1);
    step = 1'b1; auto_en = 1'b0; rst_n = 1'b0;
    #1;
    chk("r033_page", 56'(bus1.page_o), 56'd0);
    chk("r033_hex",  bus1.hex_n_o, {56{1'b1}});
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
`ifdef REG_DISPLAY_SNAPSHOT_EN
    chk("r033_reload", bus1.hex_n_o, {8{7'h40}});
`else
    chk("r033_reload", bus1.hex_n_o, {7'h79, 7'h79, 7'h24, 7'h24, 7'h06, 7'h0E, 7'h19, 7'h19});
`endif
    cyc(10);
    chk("r026_held", 56'(bus1.page_o), 56'd0);
    step = 1'b0;
    cyc(3);
    press();
    chk("r026_repress", 56'(bus1.page_o), 56'd1);
    press();

    // Snapshot versus live display of R0.
    r[0] = 16'h00AB;
    pulse_capture();
    r[0] = 16'h00CD;
    cyc(3);
`ifdef REG_DISPLAY_SNAPSHOT_EN
    chk("r032_hold", 56'(bus1.hex_n_o[55:42]), 56'({7'h08, 7'h03}));
`else
    chk("r032_live", 56'(bus1.hex_n_o[55:42]), 56'({7'h46, 7'h21}));
`endif
    pulse_capture();
    cyc(3);
    chk("r032_cap2", 56'(bus1.hex_n_o[55:42]), 56'({7'h46, 7'h21}));

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_display_pager.md
REG_DISPLAY_PAGER -- requirements
Module: reg_display_pager

Interface
REQ-001 Parameter NREG, default 8: number of registers displayed, 1..16.
REQ-002 Parameter WIDTH, default 16: register width in bits, multiple of 4, 4..32.
REQ-003 Parameter DPR, default 2: hex digits per register, one of 1/2/4/8, with 4*DPR <= WIDTH; slots per page P = 8/DPR.
REQ-004 Parameter AUTO_DIV, default 50000000: Clock cycles per auto-scroll tick, >= 2.
REQ-005 Clock  in  1  single system clock, rising-edge; one clock only.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 regs_in  in  NREG*WIDTH  flattened register values, R(i) at [i*WIDTH +: WIDTH].
REQ-008 step  in  1  asynchronous pushbutton/switch, active-high, advances the page.
REQ-009 auto_en  in  1  asynchronous level, enables auto-scroll.
REQ-010 capture  in  1  synchronous single-cycle pulse (e.g. processor done) that loads the snapshot.
REQ-011 hex_n  out  56  eight active-low 7-seg digits; digit k at [7k+6:7k]; bit 7k = segment a ... 7k+6 = segment g.
REQ-012 page  out  4  current page index.

Function
REQ-013 Page count NPAGE = ceil(NREG/P); page p, slot s (0..P-1) shows R(p*P+s).
REQ-014 Slot 0 occupies the highest digits (digit 7 downward); within a slot the leftmost digit is the most significant nibble of R[4*DPR-1:0].
REQ-015 Slots with p*P+s >= NREG show blank (all seven segments = 1).
REQ-016 Decode 0-F as standard hex glyphs (b, d lowercase); hex_n registered, updates one Clock after any page or source-value change.
REQ-017 step and auto_en pass through a two-flop synchronizer; a rising edge of synchronized step produces one advance pulse.
REQ-018 step high at a rising edge: page changes on the 3rd edge after it, hex_n on the 4th; holding step high gives exactly one advance.
REQ-019 Prescaler counts 0..AUTO_DIV-1 while synchronized auto_en = 1, emits a tick on wrap, and is held at 0 while auto_en = 0.
REQ-020 Advance: page = page+1, wrapping NPAGE-1 -> 0; NPAGE = 1 keeps page at 0.
REQ-021 Step edge and auto tick in the same cycle advance the page by one only.
REQ-022 Step advance restarts the prescaler at 0, giving a full AUTO_DIV interval before the next auto advance.
REQ-023 page is zero-extended to 4 bits.

Reset
REQ-024 reset low asynchronously forces: page = 0, prescaler = 0, synchronizer flops = 0, snapshot = 0, hex_n = all ones (blank).
REQ-025 Reset asserted mid-scroll or mid-capture discards the operation; after release the first rising edge loads decoded page-0 content into hex_n.
REQ-026 A step held high through reset release produces no advance until it is released and pressed again.

Configuration
REQ-027 Macro REG_DISPLAY_SNAPSHOT_EN defined: capture = 1 at a rising edge latches all of regs_in into the snapshot, and digits display the snapshot only.
REQ-028 REG_DISPLAY_SNAPSHOT_EN undefined: no snapshot storage; capture is ignored; digits display regs_in live.

Verification
REQ-029 NREG=6, WIDTH=16, DPR=2, reset then release, R0..R5=0x0011,0x0022,...,0x0066 -> digits 7..0 show 1 1 2 2 3 3 4 4, page=0.
REQ-030 Same setup, one step press -> page=1, digits show 5 5 6 6 then four blanks (hex_n[27:0] = all ones); second press -> page=0.
REQ-031 AUTO_DIV=4, auto_en=1, step pulsed in the cycle the tick fires -> page advances by exactly 1; the next auto advance follows 4 cycles later.
REQ-032 SNAPSHOT_EN defined, R0=0x00AB, capture pulse, then R0=0x00CD -> digits 7..6 remain A b; second capture -> C d.
REQ-033 reset pulsed low at page=1 with the prescaler mid-count -> hex_n all ones and page=0 immediately, page-0 digits one edge after release.
REQ-034 DPR=4, WIDTH=16, NREG=3, R2=0xBEEF -> page 1 shows b E E F on digits 7..4, digits 3..0 blank.
